// File: rtl/fft_frame_seq_pkg.sv
// Shared FFT pipeline defines: frame geometry, counter widths and sequencer state encodings.
// Latency: none (definitions only).
// Backpressure: not applicable.
package fft_frame_seq_pkg;

    // Frame geometry shared by the stream slave, FFT engine and output master
    localparam int FFT_SIZE_DEFAULT      = 4096;
    localparam int FFT_ADDR_WIDTH        = 12;
    // Byte address width of one frame buffer holding 32-bit samples
    localparam int FFT_BYTE_COUNT_WIDTH  = FFT_ADDR_WIDTH + 2;
    localparam int FFT_CNT_WIDTH_DEFAULT = 16;

    // Frame sequencer states; encodings are visible on the state output
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_UNLOAD  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fft_frame_seq_frame_beat_checker.sv
// Frame beat checker: counts accepted input beats, detects the final beat, flags TLAST framing errors.
// Latency: count and flags update at the accepting edge; last_beat is combinational in the beat cycle.
// Backpressure: none; it only observes accepted beats (write strobes) and never stalls the stream.
module fft_frame_seq_frame_beat_checker
    import fft_frame_seq_pkg::*;
#(
    parameter int FFT_SIZE   = FFT_SIZE_DEFAULT,
    parameter int ADDR_WIDTH = FFT_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_clear,
    input  logic                  i_we,
    input  logic                  i_tlast,
    input  logic                  i_clear_err,
    output logic [ADDR_WIDTH:0]   o_beat_count,
    output logic                  o_last_beat,
    output logic                  o_err_early_tlast,
    output logic                  o_err_missing_tlast
);

    localparam logic [ADDR_WIDTH:0] LP_LAST_IDX = (ADDR_WIDTH + 1)'(FFT_SIZE - 1);

    logic [ADDR_WIDTH:0] r_beat_count;
    logic                r_err_early;
    logic                r_err_missing;

    logic                w_at_last;
    logic                w_set_early;
    logic                w_set_missing;

    // The beat about to be accepted is the final one of the frame
    assign w_at_last     = (r_beat_count == LP_LAST_IDX);
    assign w_set_early   = i_we & i_tlast & ~w_at_last;
    assign w_set_missing = i_we & ~i_tlast & w_at_last;

    // Beat counter: cleared at frame start or abort, otherwise counts accepted beats
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_beat_count <= '0;
        end else if (i_clear) begin
            r_beat_count <= '0;
        end else if (i_we) begin
            r_beat_count <= r_beat_count + (ADDR_WIDTH + 1)'(1);
        end
    end

    // Sticky framing errors; a new error in the same cycle as clear_err wins
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            r_err_early   <= w_set_early   | (r_err_early   & ~i_clear_err);
            r_err_missing <= w_set_missing | (r_err_missing & ~i_clear_err);
        end
    end

    assign o_beat_count        = r_beat_count;
    assign o_last_beat         = i_we & w_at_last;
    assign o_err_early_tlast   = r_err_early;
    assign o_err_missing_tlast = r_err_missing;

endmodule

// File: rtl/fft_frame_seq.sv
// Frame sequencer: walks stream slave, FFT engine and output master through LOAD, COMPUTE, UNLOAD.
// Latency: each go pulse appears the cycle after its trigger; slave_reset is combinational.
// Backpressure: the slave write phase is ended after exactly FFT_SIZE accepted beats; done pulses are waited for.
module fft_frame_seq
    import fft_frame_seq_pkg::*;
#(
    parameter int FFT_SIZE   = FFT_SIZE_DEFAULT,
    parameter int ADDR_WIDTH = FFT_ADDR_WIDTH,
    parameter int CNT_WIDTH  = FFT_CNT_WIDTH_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic                  i_continuous,
    input  logic                  i_abort,
    input  logic                  i_clear_err,
    input  logic                  i_s2mem_we,
    input  logic                  i_s_axis_tlast,
    output logic                  o_slave_go,
    output logic                  o_slave_reset,
    output logic                  o_fft_go,
    input  logic                  i_fft_done,
    output logic                  o_master_go,
    input  logic                  i_master_done,
    output logic                  o_engine_flush,
    output logic                  o_busy,
    output logic [1:0]            o_state,
    output logic [ADDR_WIDTH:0]   o_beat_count,
    output logic [CNT_WIDTH-1:0]  o_frame_count,
    output logic                  o_err_early_tlast,
    output logic                  o_err_missing_tlast
);

    seq_state_t           r_state;
    logic                 r_slave_go;
    logic                 r_fft_go;
    logic                 r_master_go;
    logic                 r_engine_flush;
    logic                 r_busy;
    logic [CNT_WIDTH-1:0] r_frame_count;

    logic                 w_fft_done_ok;
    logic                 w_master_done_ok;
    logic                 w_frame_start;
    logic                 w_beat_clear;
    logic                 w_beat_we;
    logic                 w_last_beat;

    // Done pulses only count in their own state and never in the go-pulse cycle itself
    assign w_fft_done_ok    = (r_state == ST_COMPUTE) & ~r_fft_go    & i_fft_done;
    assign w_master_done_ok = (r_state == ST_UNLOAD)  & ~r_master_go & i_master_done;

    // A new frame starts from IDLE on start, or straight after UNLOAD in continuous mode
    assign w_frame_start = ~i_abort & (((r_state == ST_IDLE) & i_start) |
                                       (w_master_done_ok & i_continuous));
    assign w_beat_clear  = i_abort | w_frame_start;
    // Beats only count while loading; an abort beat is discarded
    assign w_beat_we     = i_s2mem_we & (r_state == ST_LOAD) & ~i_abort;

    fft_frame_seq_frame_beat_checker #(
        .FFT_SIZE   (FFT_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_frame_beat_checker (
        .i_clk               (i_clk),
        .i_reset_n           (i_reset_n),
        .i_clear             (w_beat_clear),
        .i_we                (w_beat_we),
        .i_tlast             (i_s_axis_tlast),
        .i_clear_err         (i_clear_err),
        .o_beat_count        (o_beat_count),
        .o_last_beat         (w_last_beat),
        .o_err_early_tlast   (o_err_early_tlast),
        .o_err_missing_tlast (o_err_missing_tlast)
    );

    // Sequencer FSM with registered one-cycle go/flush pulses, busy and frame counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            r_slave_go     <= 1'b0;
            r_fft_go       <= 1'b0;
            r_master_go    <= 1'b0;
            r_engine_flush <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            r_slave_go     <= 1'b0;
            r_fft_go       <= 1'b0;
            r_master_go    <= 1'b0;
            r_engine_flush <= 1'b0;
            if (i_abort) begin
                r_state        <= ST_IDLE;
                r_busy         <= 1'b0;
                r_engine_flush <= (r_state == ST_COMPUTE) || (r_state == ST_UNLOAD);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_state    <= ST_LOAD;
                            r_slave_go <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (w_last_beat) begin
                            r_state  <= ST_COMPUTE;
                            r_fft_go <= 1'b1;
                        end
                    end
                    ST_COMPUTE: begin
                        if (w_fft_done_ok) begin
                            r_state     <= ST_UNLOAD;
                            r_master_go <= 1'b1;
                        end
                    end
                    ST_UNLOAD: begin
                        if (w_master_done_ok) begin
                            r_frame_count <= r_frame_count + CNT_WIDTH'(1);
                            if (i_continuous) begin
                                r_state    <= ST_LOAD;
                                r_slave_go <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Slave is held in reset during chip reset, on abort, and in the final-beat cycle
    assign o_slave_reset  = ~i_reset_n | i_abort | w_last_beat;

    assign o_slave_go     = r_slave_go;
    assign o_fft_go       = r_fft_go;
    assign o_master_go    = r_master_go;
    assign o_engine_flush = r_engine_flush;
    assign o_busy         = r_busy;
    assign o_state        = r_state;
    assign o_frame_count  = r_frame_count;

endmodule

// File: tb/tb_fft_frame_seq.sv
// Testbench for fft_frame_seq with a 16-beat frame; expected pulse events go into a queue.
// A negedge monitor pops and compares whenever a go, flush or slave_reset pulse appears.
// Directed frames: nominal, gapped, TLAST errors, clear priority, continuous, abort, mid-frame reset.
module tb_fft_frame_seq;

    localparam int FS = 16;
    localparam int AW = 4;
    localparam int CW = 16;

    localparam int EV_SGO   = 0;
    localparam int EV_FGO   = 1;
    localparam int EV_MGO   = 2;
    localparam int EV_FLUSH = 3;
    localparam int EV_SRST  = 4;

    typedef struct {
        int kind;
        int st;
        int beat;
        int fc;
        int e;
        int m;
    } ev_t;

    logic          clk          = 1'b0;
    logic          reset_n      = 1'b0;
    logic          start        = 1'b0;
    logic          continuous   = 1'b0;
    logic          abort        = 1'b0;
    logic          clear_err    = 1'b0;
    logic          s2mem_we     = 1'b0;
    logic          tlast        = 1'b0;
    logic          fft_done     = 1'b0;
    logic          master_done  = 1'b0;
    logic          slave_go;
    logic          slave_reset;
    logic          fft_go;
    logic          master_go;
    logic          engine_flush;
    logic          busy;
    logic [1:0]    state;
    logic [AW:0]   beat_count;
    logic [CW-1:0] frame_count;
    logic          err_e;
    logic          err_m;

    ev_t exp_q[$];
    int  vectors    = 0;
    int  fails      = 0;
    int  m_fc       = 0;
    int  m_e        = 0;
    int  m_m        = 0;
    int  busy_watch = 0;
    int  busy_low   = 0;

    fft_frame_seq #(
        .FFT_SIZE   (FS),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk               (clk),
        .i_reset_n           (reset_n),
        .i_start             (start),
        .i_continuous        (continuous),
        .i_abort             (abort),
        .i_clear_err         (clear_err),
        .i_s2mem_we          (s2mem_we),
        .i_s_axis_tlast      (tlast),
        .o_slave_go          (slave_go),
        .o_slave_reset       (slave_reset),
        .o_fft_go            (fft_go),
        .i_fft_done          (fft_done),
        .o_master_go         (master_go),
        .i_master_done       (master_done),
        .o_engine_flush      (engine_flush),
        .o_busy              (busy),
        .o_state             (state),
        .o_beat_count        (beat_count),
        .o_frame_count       (frame_count),
        .o_err_early_tlast   (err_e),
        .o_err_missing_tlast (err_m)
    );

    always #5 clk = ~clk;

    function automatic string ev_name(input int k);
        case (k)
            EV_SGO:   return "slave_go";
            EV_FGO:   return "fft_go";
            EV_MGO:   return "master_go";
            EV_FLUSH: return "engine_flush";
            default:  return "slave_reset";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int st, input int beat);
        ev_t e;
        e.kind = kind; e.st = st; e.beat = beat;
        e.fc = m_fc; e.e = m_e; e.m = m_m;
        exp_q.push_back(e);
    endtask

    task automatic chk_event(input int kind);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: unexpected %s pulse (state=%0d beat=%0d)", ev_name(kind),
                     int'(state), int'(beat_count));
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || int'(state) != e.st || int'(beat_count) != e.beat ||
                int'(frame_count) != e.fc || int'(err_e) != e.e || int'(err_m) != e.m) begin
                fails++;
                $display("FAIL event: got %s st=%0d beat=%0d fc=%0d early=%0d missing=%0d, expected %s st=%0d beat=%0d fc=%0d early=%0d missing=%0d",
                         ev_name(kind), int'(state), int'(beat_count), int'(frame_count),
                         int'(err_e), int'(err_m), ev_name(e.kind), e.st, e.beat, e.fc, e.e, e.m);
            end
        end
    endtask

    // Monitor: compares every pulse against the next expected event
    always @(negedge clk) begin
        if (reset_n) begin
            if (busy_watch != 0 && !busy) busy_low = 1;
            if (slave_go)     chk_event(EV_SGO);
            if (fft_go)       chk_event(EV_FGO);
            if (master_go)    chk_event(EV_MGO);
            if (engine_flush) chk_event(EV_FLUSH);
            if (slave_reset)  chk_event(EV_SRST);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ends in the slave_go cycle
    task automatic start_frame();
        start = 1'b1;
        push_ev(EV_SGO, 1, 0);
        tick();
        start = 1'b0;
    endtask

    // Delivers n beats; ends in the cycle after the last beat
    task automatic load_beats(input int n, input int gap, input int early_beat,
                              input bit last_tl, input int clr_beat);
        bit tl;
        bit se;
        bit sm;
        bit clr;
        tick();
        for (int i = 0; i < n; i++) begin
            tl  = (i == early_beat) || (i == FS - 1 && last_tl);
            clr = (i == clr_beat);
            s2mem_we  = 1'b1;
            tlast     = tl;
            clear_err = clr;
            if (i == FS - 1) push_ev(EV_SRST, 1, FS - 1);
            se  = tl && (i != FS - 1);
            sm  = !tl && (i == FS - 1);
            m_e = (se || (m_e != 0 && !clr)) ? 1 : 0;
            m_m = (sm || (m_m != 0 && !clr)) ? 1 : 0;
            if (i == FS - 1) push_ev(EV_FGO, 2, FS);
            tick();
            s2mem_we  = 1'b0;
            tlast     = 1'b0;
            clear_err = 1'b0;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (g == 0) begin
                        check("gap beat_count", int'(beat_count), i + 1);
                        check("gap state", int'(state), 1);
                    end
                    tick();
                end
            end
        end
    endtask

    // Starts in the fft_go cycle; ends in the cycle after master_done
    task automatic compute_unload(input int lat, input bit ign, input bit cont_after);
        if (ign) begin
            fft_done = 1'b1;
            tick();
            fft_done = 1'b0;
            check("fft_done in go cycle ignored", int'(state), 2);
        end
        repeat (lat) tick();
        fft_done = 1'b1;
        push_ev(EV_MGO, 3, FS);
        tick();
        fft_done = 1'b0;
        if (ign) begin
            master_done = 1'b1;
            tick();
            master_done = 1'b0;
            check("master_done in go cycle ignored", int'(state), 3);
            check("frame_count held", int'(frame_count), m_fc);
        end
        repeat (lat) tick();
        continuous  = cont_after;
        master_done = 1'b1;
        m_fc++;
        if (cont_after) push_ev(EV_SGO, 1, 0);
        else busy_watch = 0;
        tick();
        master_done = 1'b0;
        check("frame_count after unload", int'(frame_count), m_fc);
        check("state after unload", int'(state), cont_after ? 1 : 0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset state", int'(state), 0);
        check("reset busy", int'(busy), 0);
        check("reset go pulses", int'({slave_go, fft_go, master_go, engine_flush}), 0);
        check("reset beat_count", int'(beat_count), 0);
        check("reset frame_count", int'(frame_count), 0);
        check("reset error flags", int'({err_e, err_m}), 0);
        check("reset slave_reset", int'(slave_reset), 1);
        reset_n = 1'b1;
        tick();

        // Nominal frame
        start_frame();
        load_beats(FS, 0, -1, 1'b1, -1);
        compute_unload(3, 1'b0, 1'b0);
        check("nominal err flags", int'({err_e, err_m}), 0);
        check("nominal busy", int'(busy), 0);

        // Gapped input, plus done pulses during go cycles
        start_frame();
        load_beats(FS, 3, -1, 1'b1, -1);
        compute_unload(1, 1'b1, 1'b0);

        // Early TLAST on beat 7
        start_frame();
        load_beats(FS, 0, 7, 1'b1, -1);
        compute_unload(2, 1'b0, 1'b0);
        check("early tlast flag", int'(err_e), 1);
        check("early tlast no missing", int'(err_m), 0);

        // Missing TLAST on beat 15
        start_frame();
        load_beats(FS, 0, -1, 1'b0, -1);
        compute_unload(2, 1'b0, 1'b0);
        check("missing tlast flag", int'(err_m), 1);
        check("early flag sticky", int'(err_e), 1);

        // clear_err
        clear_err = 1'b1;
        m_e = 0;
        m_m = 0;
        tick();
        clear_err = 1'b0;
        check("clear_err flags", int'({err_e, err_m}), 0);

        // Set beats clear when an early TLAST coincides with clear_err
        start_frame();
        load_beats(FS, 0, 3, 1'b1, 3);
        compute_unload(2, 1'b0, 1'b0);
        check("set wins over clear", int'(err_e), 1);
        clear_err = 1'b1;
        m_e = 0;
        tick();
        clear_err = 1'b0;
        check("clear_err again", int'(err_e), 0);

        // Continuous mode: three frames back to back
        busy_low = 0;
        start_frame();
        busy_watch = 1;
        for (int f = 0; f < 3; f++) begin
            load_beats(FS, 0, -1, 1'b1, -1);
            compute_unload(2, 1'b0, f < 2);
        end
        check("continuous busy never dropped", busy_low, 0);
        check("continuous frame_count", int'(frame_count), 8);

        // Abort at beat 5 of LOAD, with a strobe in the abort cycle
        start_frame();
        load_beats(5, 0, -1, 1'b1, -1);
        abort    = 1'b1;
        s2mem_we = 1'b1;
        push_ev(EV_SRST, 1, 5);
        tick();
        abort    = 1'b0;
        s2mem_we = 1'b0;
        check("load abort state", int'(state), 0);
        check("load abort beat_count", int'(beat_count), 0);
        check("load abort frame_count", int'(frame_count), 8);
        check("load abort no flush", int'(engine_flush), 0);
        check("load abort busy", int'(busy), 0);

        // Abort in COMPUTE
        start_frame();
        load_beats(FS, 0, -1, 1'b1, -1);
        tick();
        abort = 1'b1;
        push_ev(EV_SRST, 2, FS);
        push_ev(EV_FLUSH, 0, 0);
        tick();
        abort = 1'b0;
        tick();
        check("flush one cycle", int'(engine_flush), 0);
        check("compute abort state", int'(state), 0);
        check("compute abort frame_count", int'(frame_count), 8);

        // Reset mid-UNLOAD
        start_frame();
        load_beats(FS, 0, -1, 1'b1, -1);
        tick();
        fft_done = 1'b1;
        push_ev(EV_MGO, 3, FS);
        tick();
        fft_done = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("mid reset state", int'(state), 0);
        check("mid reset busy", int'(busy), 0);
        check("mid reset go pulses", int'({slave_go, fft_go, master_go, engine_flush}), 0);
        check("mid reset beat_count", int'(beat_count), 0);
        check("mid reset frame_count", int'(frame_count), 0);
        check("mid reset slave_reset", int'(slave_reset), 1);
        m_fc = 0;
        m_e  = 0;
        m_m  = 0;
        tick();
        reset_n = 1'b1;
        tick();

        // Frame after reset
        start_frame();
        load_beats(FS, 0, -1, 1'b1, -1);
        compute_unload(1, 1'b0, 1'b0);

        tick();
        tick();
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            vectors++;
            fails++;
            $display("FAIL event: expected %s pulse never seen", ev_name(e.kind));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: run did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
